// File: rtl/ls_down_timer_pkg.sv
// ----------------------------------------------------------------------------
// ls_timer_pkg
//   Shared definitions for the ls_down_timer slice: FSM state encoding,
//   counter slice width and the default counter width.
//   Ports: none (package).
//   Build option: LS_DOWN_TIMER_AUTO_RELOAD_EN (consumed by ls_down_timer).
// ----------------------------------------------------------------------------
package ls_timer_pkg;

   // Timer control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Every counter is built from slices of this many bits
   localparam int SLICE_W = 4;

   // Default counter width (legal: multiples of SLICE_W, 4..32)
   localparam int WIDTH_DEFAULT = 8;

endpackage : ls_timer_pkg

// File: rtl/ls_down_timer_if.sv
// ----------------------------------------------------------------------------
// ls_down_timer_if
//   Groups the timer's control and status signals.
//   Signals:
//     D       parallel preset value
//     LOAD_n  active-low synchronous parallel load
//     START   start / restart request (level, sampled on CLK)
//     ENP     parallel count enable
//     ENT     trickle count enable, also gates BO
//     Q       current count (registered)
//     BO      borrow out (combinational)
//     TC      one-cycle terminal-count pulse (registered)
//     BUSY    high while counting
//   Modports: master drives the controls, slave is the timer itself.
// ----------------------------------------------------------------------------
interface ls_down_timer_if #(
   parameter int WIDTH = ls_timer_pkg::WIDTH_DEFAULT
);

   logic [WIDTH-1:0] D;
   logic             LOAD_n;
   logic             START;
   logic             ENP;
   logic             ENT;
   logic [WIDTH-1:0] Q;
   logic             BO;
   logic             TC;
   logic             BUSY;

   modport master (
      output D, LOAD_n, START, ENP, ENT,
      input  Q, BO, TC, BUSY
   );

   modport slave (
      input  D, LOAD_n, START, ENP, ENT,
      output Q, BO, TC, BUSY
   );

endinterface : ls_down_timer_if

// File: rtl/ls_down_timer_slice.sv
// ----------------------------------------------------------------------------
// ls_down_slice
//   4-bit presettable down-counter slice. Slices are chained through their
//   borrow signals: a slice decrements only when its borrow_in is high,
//   i.e. the count is enabled and every lower slice holds zero.
//   Ports:
//     CLK         clock, rising edge
//     CLR         asynchronous active-high clear
//     load        synchronous load of d (wins over decrement)
//     d           load value
//     borrow_in   decrement request from the lower slices
//     q           slice value
//     borrow_out  borrow to the next slice (borrow_in AND q==0)
// ----------------------------------------------------------------------------
module ls_down_slice
   import ls_timer_pkg::*;
(
   input  logic               CLK,
   input  logic               CLR,
   input  logic               load,
   input  logic [SLICE_W-1:0] d,
   input  logic               borrow_in,
   output logic [SLICE_W-1:0] q,
   output logic               borrow_out
);

   logic [SLICE_W-1:0] q_r;

   // Slice value register: clear, load, decrement or hold
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         q_r <= {SLICE_W{1'b0}};
      end else if (load) begin
         q_r <= d;
      end else if (borrow_in) begin
         q_r <= q_r - {{(SLICE_W-1){1'b0}}, 1'b1};
      end else begin
         q_r <= q_r;
      end
   end

   assign q          = q_r;
   // A slice at zero passes the borrow on, and wraps itself to all-ones
   assign borrow_out = borrow_in & (q_r == {SLICE_W{1'b0}});

endmodule : ls_down_slice

// File: rtl/ls_down_timer.sv
// ----------------------------------------------------------------------------
// ls_down_timer
//   Loadable down-timer with START/DONE control, built from chained 4-bit
//   down-counter slices. Priority per edge: CLR > LOAD_n > START > count.
//   Ports:
//     CLK   clock, all state changes on the rising edge
//     CLR   asynchronous active-high reset
//     bus   ls_down_timer_if.slave (D, LOAD_n, START, ENP, ENT in;
//           Q, BO, TC, BUSY out)
//   Parameter:
//     WIDTH counter width, multiple of 4 in 4..32
//   Build option:
//     LS_DOWN_TIMER_AUTO_RELOAD_EN - when defined, reaching zero reloads the
//     count from RELOAD and keeps running (periodic TC). Without it, or when
//     RELOAD is zero, the timer stops in DONE at zero.
// ----------------------------------------------------------------------------
module ls_down_timer
   import ls_timer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
)
(
   input logic            CLK,
   input logic            CLR,
   ls_down_timer_if.slave bus
);

   localparam int NSL = WIDTH / SLICE_W;

   state_e           state_r;
   state_e           state_nxt_s;
   logic [WIDTH-1:0] reload_r;
   logic [WIDTH-1:0] reload_nxt_s;
   logic [WIDTH-1:0] load_val_s;
   logic [WIDTH-1:0] q_s;
   logic             load_s;
   logic             cnt_en_s;
   logic             tc_r;
   logic             tc_nxt_s;
   logic             busy_r;
   logic             q_zero_s;
   logic             q_one_s;
   logic [NSL:0]     borrow_s;
   logic             chain_unused_s;

   assign q_zero_s = (q_s == {WIDTH{1'b0}});
   assign q_one_s  = (q_s == {{(WIDTH-1){1'b0}}, 1'b1});

   // ------------------------------------------------------------------------
   // Borrow-chained counter slices
   // ------------------------------------------------------------------------
   assign borrow_s[0] = cnt_en_s;

   for (genvar k = 0; k < NSL; k++) begin : g_slice
      ls_down_slice u_slice (
         .CLK        (CLK),
         .CLR        (CLR),
         .load       (load_s),
         .d          (load_val_s[k*SLICE_W +: SLICE_W]),
         .borrow_in  (borrow_s[k]),
         .q          (q_s[k*SLICE_W +: SLICE_W]),
         .borrow_out (borrow_s[k+1])
      );
   end

   // Counting is never enabled at zero, so the top borrow never fires
   assign chain_unused_s = borrow_s[NSL];

   // ------------------------------------------------------------------------
   // Control registers: state, reload value, TC pulse and BUSY
   // ------------------------------------------------------------------------
   // State, reload and registered status outputs
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_r  <= IDLE;
         reload_r <= {WIDTH{1'b0}};
         tc_r     <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         reload_r <= reload_nxt_s;
         tc_r     <= tc_nxt_s;
         busy_r   <= (state_nxt_s == RUN);
      end
   end

   // Next state, slice load/count controls and TC decision
   always_comb begin
      state_nxt_s  = state_r;
      reload_nxt_s = reload_r;
      load_s       = 1'b0;
      load_val_s   = q_s;
      cnt_en_s     = 1'b0;
      tc_nxt_s     = 1'b0;

      if (!bus.LOAD_n) begin
         // Parallel load overrides everything except CLR
         load_s       = 1'b1;
         load_val_s   = bus.D;
         reload_nxt_s = bus.D;
         state_nxt_s  = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               // A zero count has nothing to time, so START is ignored
               if (bus.START && !q_zero_s) begin
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = IDLE;
               end
            end

            RUN: begin
               // START is meaningless while running; only the enables matter
               if (bus.ENP && bus.ENT && !q_zero_s) begin
                  if (q_one_s) begin
                     tc_nxt_s = 1'b1;
`ifdef LS_DOWN_TIMER_AUTO_RELOAD_EN
                     if (reload_r != {WIDTH{1'b0}}) begin
                        // Skip the zero state: wrap straight back to RELOAD
                        load_s     = 1'b1;
                        load_val_s = reload_r;
                     end else begin
                        cnt_en_s    = 1'b1;
                        state_nxt_s = DONE;
                     end
`else
                     cnt_en_s    = 1'b1;
                     state_nxt_s = DONE;
`endif
                  end else begin
                     cnt_en_s = 1'b1;
                  end
               end else begin
                  cnt_en_s = 1'b0;
               end
            end

            DONE: begin
               if (bus.START && (reload_r != {WIDTH{1'b0}})) begin
                  load_s      = 1'b1;
                  load_val_s  = reload_r;
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = DONE;
               end
            end

            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.Q    = q_s;
   assign bus.TC   = tc_r;
   assign bus.BUSY = busy_r;
   assign bus.BO   = q_zero_s & bus.ENT & (state_r == RUN);

endmodule : ls_down_timer

// File: tb/tb_ls_down_timer.sv
// ----------------------------------------------------------------------------
// tb_ls_down_timer
//   Self-checking bench for ls_down_timer: directed scenarios followed by a
//   randomized phase, all compared against a behavioural model of the timer.
// ----------------------------------------------------------------------------
module tb_ls_down_timer;

   localparam int W = 8;

`ifdef LS_DOWN_TIMER_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk = 1'b0;
   logic clr;

   ls_down_timer_if #(.WIDTH(W)) bus ();

   ls_down_timer #(.WIDTH(W)) dut (
      .CLK (clk),
      .CLR (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: mode of operation, count, reload value, TC pulse
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;
   int          m_mode;
   int unsigned m_q;
   int unsigned m_rel;
   bit          m_tc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_mode = M_IDLE;
      m_q    = 0;
      m_rel  = 0;
      m_tc   = 1'b0;
   endtask

   // One rising edge worth of behaviour, from the inputs currently applied
   task automatic model_edge();
      bit tc_next;
      tc_next = 1'b0;
      if (!bus.LOAD_n) begin
         m_q    = 32'(bus.D);
         m_rel  = 32'(bus.D);
         m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
         if (bus.START && m_q != 0) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (bus.ENP && bus.ENT && m_q != 0) begin
            if (m_q == 1) begin
               tc_next = 1'b1;
               if (AUTO && m_rel != 0) begin
                  m_q = m_rel;
               end else begin
                  m_q    = 0;
                  m_mode = M_DONE;
               end
            end else begin
               m_q = m_q - 1;
            end
         end
      end else begin
         if (bus.START && m_rel != 0) begin
            m_q    = m_rel;
            m_mode = M_RUN;
         end
      end
      m_tc = tc_next;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " Q"},    32'(bus.Q),    m_q);
      chk({tag, " TC"},   32'(bus.TC),   32'(m_tc));
      chk({tag, " BUSY"}, 32'(bus.BUSY), 32'(m_mode == M_RUN));
      chk({tag, " BO"},   32'(bus.BO),   32'(m_q == 0 && bus.ENT && m_mode == M_RUN));
   endtask

   // Apply inputs, take one edge, then compare at the falling edge
   task automatic cyc(input bit ld_n, input bit st, input bit enp, input bit ent,
                      input logic [W-1:0] d, input string tag);
      bus.LOAD_n = ld_n;
      bus.START  = st;
      bus.ENP    = enp;
      bus.ENT    = ent;
      bus.D      = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model(tag);
   endtask

   // Asynchronous clear pulse between edges; outputs must react immediately
   task automatic do_clear(input string tag);
      clr = 1'b1;
      #1;
      model_clear();
      check_model(tag);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      int k;
      int tc_seen;
      logic [W-1:0] dv;

      clr        = 1'b1;
      bus.LOAD_n = 1'b1;
      bus.START  = 1'b0;
      bus.ENP    = 1'b0;
      bus.ENT    = 1'b0;
      bus.D      = '0;
      model_clear();
      #2;
      check_model("reset");
      @(negedge clk);
      clr = 1'b0;

      // Basic run from 5 down to 0
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'd5, "s1 load");
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd5, "s1 start");
      chk("s1 q after start", 32'(bus.Q), 32'd5);
      tc_seen = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, "s1 run");
         chk("s1 seq", 32'(bus.Q), 32'(AUTO && i == 4 ? 5 : 4 - i));
         if (bus.TC) tc_seen++;
      end
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, "s1 after");
      if (bus.TC) tc_seen++;
      chk("s1 tc pulses", 32'(tc_seen), 32'd1);
`ifndef LS_DOWN_TIMER_AUTO_RELOAD_EN
      chk("s1 busy fell", 32'(bus.BUSY), 32'd0);
`endif

      // Hold for four cycles mid-run: START to TC takes 3+4 edges
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'd3, "s2 load");
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd0, "s2 start");
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, "s2 run");
      k = 1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, "s2 hold");
         chk("s2 held q", 32'(bus.Q), 32'd2);
         k++;
      end
      while (!bus.TC && k < 20) begin
         cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, "s2 resume");
         k++;
      end
      chk("s2 start to tc", 32'(k), 32'd7);

      // Borrow across the slice boundary
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, "s3 load");
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "s3 start");
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "s3 dec");
      chk("s3 q 0F", 32'(bus.Q), 32'h0F);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "s3 ent low");
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "s3 run");

      // Clear mid-run at Q=2, then START without load is ignored
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'd5, "s4 load");
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd0, "s4 start");
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, "s4 run");
      chk("s4 q before clr", 32'(bus.Q), 32'd2);
      do_clear("s4 clr");
      chk("s4 busy clr", 32'(bus.BUSY), 32'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd0, "s4 start ignored");
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, "s4 idle");

      // LOAD_n and START on the same edge: load wins
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'd7, "s5 load+start");
      chk("s5 q", 32'(bus.Q), 32'd7);
      chk("s5 busy", 32'(bus.BUSY), 32'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd0, "s5 start");
      chk("s5 busy after start", 32'(bus.BUSY), 32'd1);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, "s5 run");
      // Restart from DONE (or while running under auto-reload)
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd0, "s5 restart");
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, "s5 rerun");

`ifdef LS_DOWN_TIMER_AUTO_RELOAD_EN
      // Periodic TC every three enabled counts
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'd3, "s6 load");
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd0, "s6 start");
      tc_seen = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, "s6 run");
         if (bus.TC) tc_seen++;
         chk("s6 busy", 32'(bus.BUSY), 32'd1);
      end
      chk("s6 tc pulses", 32'(tc_seen), 32'd3);
`endif

      // Randomized phase
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 2) do_clear("rnd clr");
         if ($urandom_range(0, 4) == 0) dv = '0;
         else if ($urandom_range(0, 9) == 0) dv = W'($urandom_range(0, 255));
         else dv = W'($urandom_range(1, 12));
         cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), dv, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_ls_down_timer

// File: doc/ls_down_timer.md
LS_DOWN_TIMER -- requirements
Module: ls_down_timer

Interface
REQ-001 Parameter: WIDTH, 8, counter width in bits; legal values are multiples of 4, from 4 to 32.
REQ-002 Port: CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: CLR  input  1  reset, asynchronous and active-high.
REQ-004 Port: D  input  WIDTH  parallel preset value.
REQ-005 Port: LOAD_n  input  1  active-low synchronous parallel load.
REQ-006 Port: START  input  1  start or restart request, level sampled on the clock edge.
REQ-007 Port: ENP  input  1  count enable, parallel.
REQ-008 Port: ENT  input  1  count enable, trickle; also gates BO.
REQ-009 Port: Q  output  WIDTH  current count, registered.
REQ-010 Port: BO  output  1  borrow out, combinational: Q==0 AND ENT AND state==RUN.
REQ-011 Port: TC  output  1  registered one-cycle terminal-count pulse.
REQ-012 Port: BUSY  output  1  high while state==RUN.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 Per-edge priority SHALL be CLR > LOAD_n > START > count.
REQ-015 LOAD_n=0 in any state SHALL perform all of the following on that edge: Q<=D, RELOAD<=D, state<=IDLE, TC<=0.
REQ-016 START in IDLE SHALL go to RUN if Q!=0; otherwise START SHALL be ignored.
REQ-017 START in DONE SHALL set Q<=RELOAD and go to RUN if RELOAD!=0; otherwise the block SHALL stay in DONE.
REQ-018 START in RUN SHALL have no effect.
REQ-019 In RUN with ENP&ENT=1, Q SHALL decrement by 1 per edge.
REQ-020 In RUN with ENP&ENT=0, Q SHALL hold.
REQ-021 The decrement from Q=1 SHALL assert TC for exactly the following cycle; TC SHALL be 0 at all other times.
REQ-022 Q SHALL never wrap from 0 to all-ones.
REQ-023 Counting SHALL use borrow-chained 4-bit slices; slice k decrements only when all lower slices are 0 and the count is enabled.
REQ-024 Latency: START accepted at edge N gives BUSY=1 after N; the first decrement occurs at edge N+1.
REQ-025 Q and BUSY SHALL change only on CLK edges or on CLR; BO SHALL be the only combinational output.

Reset
REQ-026 CLR=1 SHALL immediately force Q=0, RELOAD=0, state=IDLE, TC=0 and BUSY=0.
REQ-027 CLR SHALL override LOAD_n and START.
REQ-028 CLR asserted mid-RUN SHALL abort the count with no TC pulse.
REQ-029 After CLR deasserts, the block SHALL act only on inputs sampled at the first subsequent CLK edge.

Configuration
REQ-030 Macro LS_DOWN_TIMER_AUTO_RELOAD_EN SHALL select the reload behaviour.
REQ-031 Macro defined: the decrement from Q=1 SHALL load Q<=RELOAD, pulse TC and keep state RUN, giving a periodic TC every RELOAD enabled counts.
REQ-032 Macro undefined: the decrement from Q=1 SHALL set Q<=0 and state<=DONE.
REQ-033 Macro undefined: DONE SHALL hold until LOAD_n, START or CLR.
REQ-034 Either macro setting: when RELOAD=0, the block SHALL behave as in the macro-undefined case.

Structure
REQ-035 Shared package ls_timer_pkg SHALL hold the state enum (IDLE, RUN, DONE), the slice width constant 4 and the WIDTH default 8.
REQ-036 Sub-module ls_down_slice SHALL be a 4-bit presettable down counter with inputs borrow-in and load, and output borrow-out.
REQ-037 ls_down_slice SHALL be instantiated WIDTH/4 times.
REQ-038 The top level SHALL hold the FSM, RELOAD and TC.

Verification
REQ-039 Scenario: D=5, LOAD_n pulse, START, ENP=ENT=1 -> Q goes 5,4,3,2,1,0; TC=1 for exactly one cycle after Q=0; state DONE; BUSY falls.
REQ-040 Scenario: D=3, count running, ENP=0 for 4 cycles mid-run -> Q holds at its value; resumes on ENP=1; total cycles from START to TC = 3+4.
REQ-041 Scenario: D=0x10, START, run to 0x0F -> borrow crosses the slice boundary correctly; BO=1 only when Q=0 with ENT=1 in RUN.
REQ-042 Scenario: CLR pulsed mid-run at Q=2 -> Q=0 and BUSY=0 immediately, no TC; a subsequent START without a load is ignored.
REQ-043 Scenario: LOAD_n=0 and START=1 on the same edge with D=7 -> Q=7 and state IDLE; the next START begins the count.
REQ-044 Scenario, macro defined: D=3, START, ENP=ENT=1 for 9 cycles -> TC pulses every 3 cycles; Q sequence 3,2,1,3,2,1,3,2,1; BUSY stays 1.
